// File: rtl/video_fetch_sequencer.sv
// rtl/video_fetch_sequencer.sv - raster timing generator and bitplane word fetch sequencer
// Issues one req/ack read per fetch slot and hands the word to the shifter with a load strobe.
`timescale 1ns/1ps
module video_fetch_sequencer #(
  parameter int H_TOTAL       = 2048,
  parameter int H_FETCH_START = 256,
  parameter int H_ACTIVE      = 1280,
  parameter int HSYNC_WIDTH   = 150,
  parameter int V_TOTAL       = 313,
  parameter int V_START       = 63,
  parameter int V_ACTIVE      = 200,
  parameter int VSYNC_LINES   = 3
) (
  input  logic        CLOCK_32,
  input  logic        reset,
  input  logic [1:0]  i_res,
  input  logic [22:0] i_vid_base,
  output logic        o_mem_req,
  output logic [22:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic        o_sh_load,
  output logic [15:0] o_sh_data,
  output logic        o_sh_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame_start,
  output logic        o_underrun,
  input  logic        i_underrun_clr
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HX = HW + 1;

  localparam logic [HW-1:0] C_H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_WIN_START = HW'(H_FETCH_START);
  localparam logic [HW-1:0] C_WIN_PRE   = HW'(H_FETCH_START - 1);
  localparam logic [HW-1:0] C_WIN_END   = HW'(H_FETCH_START + H_ACTIVE);
  localparam logic [HW-1:0] C_HSYNC_END = HW'(HSYNC_WIDTH);
  localparam logic [HX-1:0] C_START_X   = HX'(H_FETCH_START);
  localparam logic [HX-1:0] C_END_X     = HX'(H_FETCH_START + H_ACTIVE);
  localparam logic [VW-1:0] C_V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_START   = VW'(V_START);
  localparam logic [VW-1:0] C_V_END     = VW'(V_START + V_ACTIVE);
  localparam logic [VW-1:0] C_VSYNC_END = VW'(VSYNC_LINES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_LOAD1 = 2'd2,
    S_LOAD2 = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [HW-1:0]   r_hcount;
  logic [VW-1:0]   r_vcount;
  logic [4:0]      r_slot;
  logic [4:0]      r_slot_cnt;
  logic [22:0]     r_addr;
  logic [22:0]     r_mem_addr;
  logic [15:0]     r_sh_data;
  logic            r_sh_load;
  logic            r_sh_de;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_frame_start;
  logic            r_underrun;

  logic [4:0]      w_slot_next;
  logic            w_active_line;
  logic            w_in_window;
  logic            w_boundary;
  logic            w_de_window;
  logic [HX-1:0]   w_h_ext;
  logic [HX-1:0]   w_slot4;
  logic            w_issue;
  logic            w_capture;
  logic            w_skip;

  always_comb begin
    case (i_res)
      2'd1:    w_slot_next = 5'd8;
      2'd2:    w_slot_next = 5'd4;
      default: w_slot_next = 5'd16;
    endcase
  end

  assign w_active_line = (r_vcount >= C_V_START) && (r_vcount < C_V_END);
  assign w_in_window   = w_active_line && (r_hcount >= C_WIN_START) && (r_hcount < C_WIN_END);
  assign w_boundary    = w_in_window && (r_slot_cnt == 5'd0);

  // DE trails the fetch window by four slots so all planes are loaded before display.
  assign w_h_ext     = {1'b0, r_hcount};
  assign w_slot4     = HX'({r_slot, 2'b00});
  assign w_de_window = w_active_line && (w_h_ext >= C_START_X + w_slot4) &&
                       (w_h_ext < C_END_X + w_slot4);

  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    o_mem_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_boundary) begin
          w_issue      = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_capture    = 1'b1;
          w_state_next = S_LOAD1;
        end
      end
      S_LOAD1: w_state_next = S_LOAD2;
      default: w_state_next = S_IDLE;
    endcase
    w_skip = w_boundary && (r_state != S_IDLE);
  end

  always_ff @(posedge CLOCK_32 or posedge reset) begin
    if (reset) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_slot        <= 5'd16;
      r_slot_cnt    <= 5'd0;
      r_addr        <= 23'd0;
      r_mem_addr    <= 23'd0;
      r_sh_data     <= 16'd0;
      r_sh_load     <= 1'b0;
      r_sh_de       <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_hcount <= (r_hcount == C_H_LAST) ? '0 : r_hcount + 1'b1;
      if (r_hcount == C_H_LAST) begin
        r_vcount <= (r_vcount == C_V_LAST) ? '0 : r_vcount + 1'b1;
      end
      if (r_hcount == '0) begin
        r_slot <= w_slot_next;
      end
      if (r_hcount == C_WIN_PRE || r_slot_cnt == r_slot - 5'd1) begin
        r_slot_cnt <= 5'd0;
      end else begin
        r_slot_cnt <= r_slot_cnt + 5'd1;
      end
      // A skipped slot still consumes its word so later slots keep their screen position.
      if (r_hcount == '0 && r_vcount == '0) begin
        r_addr <= i_vid_base;
      end else begin
        r_addr <= r_addr + 23'(w_capture) + 23'(w_skip);
      end
      if (w_issue) begin
        r_mem_addr <= r_addr;
      end
      if (w_capture) begin
        r_sh_data <= i_mem_rdata;
      end
      r_sh_load     <= (r_state == S_LOAD1) || (r_state == S_LOAD2);
      r_sh_de       <= w_de_window;
      r_hsync       <= r_hcount < C_HSYNC_END;
      r_vsync       <= r_vcount < C_VSYNC_END;
      r_frame_start <= (r_hcount == '0) && (r_vcount == '0);
      if (i_underrun_clr) begin
        r_underrun <= 1'b0;
      end else if (w_skip) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign o_mem_addr    = r_mem_addr;
  assign o_sh_data     = r_sh_data;
  assign o_sh_load     = r_sh_load;
  assign o_sh_de       = r_sh_de;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_video_fetch_sequencer.sv
// tb/tb_video_fetch_sequencer.sv - self-checking bench for video_fetch_sequencer
// Short frame (6 lines) keeps the run small; line timing is the full 2048-cycle line.
`timescale 1ns/1ps
module tb_video_fetch_sequencer;

  localparam int VT = 6;
  localparam int VS = 1;
  localparam int VA = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  res = 2'd0;
  logic [22:0] vid_base = 23'd0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'd0;
  logic        underrun_clr = 1'b0;
  logic        mem_req, sh_load, sh_de, hsync, vsync, frame_start, underrun;
  logic [22:0] mem_addr;
  logic [15:0] sh_data;

  int checks = 0;
  int errors = 0;
  int hpos = -1;
  int vpos = -1;
  bit cap = 1'b0;
  bit addr_unstable = 1'b0;

  int          req_h[$];
  int          req_v[$];
  logic [22:0] req_a[$];
  logic [15:0] load_d[$];
  int          de_h[$];
  bit          de_v[$];
  int          exp_h[$];
  logic [22:0] exp_a[$];
  logic [15:0] exp_d[$];

  logic [22:0] model_addr;
  logic [31:0] seed;
  int          base_delay = 0;
  int          delay_special = 0;
  logic [22:0] delay_addr = 23'h7fffff;

  video_fetch_sequencer #(
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .VSYNC_LINES(1)
  ) dut (
    .CLOCK_32(clk), .reset(reset), .i_res(res), .i_vid_base(vid_base),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata), .o_sh_load(sh_load), .o_sh_data(sh_data),
    .o_sh_de(sh_de), .o_hsync(hsync), .o_vsync(vsync),
    .o_frame_start(frame_start), .o_underrun(underrun),
    .i_underrun_clr(underrun_clr)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] fdata(input logic [22:0] a);
    logic [31:0] t;
    t = ({9'd0, a} * 32'h9E3779B1) ^ seed;
    return t[31:16];
  endfunction

  // Expected fetches of one line: one word per slot from the line start address.
  function automatic void build_expect(input int slot, input logic [22:0] start, input int skip);
    exp_h.delete(); exp_a.delete(); exp_d.delete();
    for (int k = 0; k < 1280 / slot; k++) begin
      if (k != skip) begin
        exp_h.push_back(256 + slot * k);
        exp_a.push_back(start + 23'(k));
        exp_d.push_back(fdata(start + 23'(k)));
      end
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (req_h.size() < exp_h.size()) ? req_h.size() : exp_h.size();
    if (load_d.size() < n) n = load_d.size();
    for (int k = 0; k < n; k++) begin
      if (req_h[k] !== exp_h[k] || req_a[k] !== exp_a[k] || load_d[k] !== exp_d[k]) return k;
    end
    return -1;
  endfunction

  // Memory responder: ack after a per-request number of extra wait cycles.
  initial begin : responder
    int wcnt;
    int d;
    wcnt = 0;
    d = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt == 0) d = (mem_addr == delay_addr) ? delay_special : base_delay;
        if (wcnt >= d) begin
          mem_ack = 1'b1;
          mem_rdata = fdata(mem_addr);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
        end
        wcnt++;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        wcnt = 0;
      end
    end
  end

  // Monitor: raster position relative to frame_start plus event logs.
  initial begin : monitor
    logic p_req, p_load, p_de;
    logic [22:0] p_addr;
    p_req = 1'b0; p_load = 1'b0; p_de = 1'b0; p_addr = 23'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hpos = -1; vpos = -1;
      end else if (frame_start) begin
        hpos = 0; vpos = 0;
      end else if (hpos >= 0) begin
        hpos++;
        if (hpos == 2048) begin
          hpos = 0;
          vpos = (vpos + 1) % VT;
        end
      end
      if (cap) begin
        if (mem_req && !p_req) begin
          req_h.push_back(hpos); req_v.push_back(vpos); req_a.push_back(mem_addr);
        end
        if (sh_load && !p_load) load_d.push_back(sh_data);
        if (sh_de !== p_de) begin
          de_h.push_back(hpos); de_v.push_back(sh_de);
        end
      end
      if (mem_req && p_req && mem_addr !== p_addr) addr_unstable = 1'b1;
      p_req = mem_req; p_load = sh_load; p_de = sh_de; p_addr = mem_addr;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pos(input int v, input int h);
    int n;
    n = 0;
    while (!(vpos == v && hpos == h) && n < 40000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40000) begin
      errors++;
      $display("FAIL wait_pos timeout at v=%0d h=%0d, wanted v=%0d h=%0d", vpos, hpos, v, h);
    end
  endtask

  task automatic clear_logs();
    req_h.delete(); req_v.delete(); req_a.delete(); load_d.delete();
    de_h.delete(); de_v.delete();
    addr_unstable = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] base0;
    base0 = 23'($urandom);
    vid_base = base0;
    res = 2'd0;
    reset = 1'b1;
    repeat (4) step();
    checks++;
    if ({mem_req, sh_load, sh_de, hsync, vsync, frame_start, underrun} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {mem_req, sh_load, sh_de, hsync, vsync, frame_start, underrun});
    end
    checks++;
    if (mem_addr !== 23'd0 || sh_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h want 0", mem_addr, sh_data);
    end
    reset = 1'b0;
    step();
    checks++;
    if (frame_start !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
      errors++;
      $display("FAIL first_line_sync got fs=%b hs=%b vs=%b want 111", frame_start, hsync, vsync);
    end
    step();
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_width got %b want 0", frame_start);
    end
    model_addr = base0;
  endtask

  task automatic test_low();
    logic [22:0] start;
    int bad;
    wait_pos(1, 0);
    clear_logs();
    cap = 1'b1;
    start = model_addr;
    wait_pos(1, 1800);
    cap = 1'b0;
    res = 2'd2;
    build_expect(16, start, -1);
    checks++;
    if (req_h.size() !== 80 || load_d.size() !== 80) begin
      errors++;
      $display("FAIL low_count got req=%0d load=%0d want 80", req_h.size(), load_d.size());
    end
    bad = first_diff();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("FAIL low_fetch word %0d got h=%0d a=%h d=%h want h=%0d a=%h d=%h", bad,
               req_h[bad], req_a[bad], load_d[bad], exp_h[bad], exp_a[bad], exp_d[bad]);
    end
    checks++;
    if (de_h.size() !== 2 || de_h[0] !== 320 || de_h[1] !== 1600 || de_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL low_de got edges=%0d first=%0d want 2 edges at 320 and 1600",
               de_h.size(), (de_h.size() > 0) ? de_h[0] : -1);
    end
    model_addr = start + 23'd80;
  endtask

  task automatic test_mono();
    logic [22:0] a2;
    int bad;
    wait_pos(2, 0);
    clear_logs();
    cap = 1'b1;
    a2 = model_addr;
    wait_pos(2, 1800);
    build_expect(4, a2, -1);
    bad = first_diff();
    checks++;
    if (req_h.size() !== 320 || load_d.size() !== 320 || bad !== -1) begin
      errors++;
      $display("FAIL mono_line2 got req=%0d load=%0d diff=%0d want 320 320 -1",
               req_h.size(), load_d.size(), bad);
    end
    checks++;
    if (de_h.size() !== 2 || de_h[0] !== 272 || de_h[1] !== 1552) begin
      errors++;
      $display("FAIL mono_de got edges=%0d first=%0d want 272 and 1552",
               de_h.size(), (de_h.size() > 0) ? de_h[0] : -1);
    end
    wait_pos(3, 0);
    clear_logs();
    wait_pos(3, 1800);
    cap = 1'b0;
    build_expect(4, a2 + 23'd320, -1);
    bad = first_diff();
    checks++;
    if (req_a.size() == 0 || req_a[0] !== a2 + 23'd320) begin
      errors++;
      $display("FAIL mono_line_step got %h want %h", (req_a.size() > 0) ? req_a[0] : 23'h0,
               a2 + 23'd320);
    end
    checks++;
    if (req_h.size() !== 320 || bad !== -1) begin
      errors++;
      $display("FAIL mono_line3 got req=%0d diff=%0d want 320 -1", req_h.size(), bad);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL mono_underrun got %b want 0", underrun);
    end
    model_addr = 23'($urandom);
    vid_base = model_addr;
  endtask

  task automatic test_underrun();
    logic [22:0] start;
    int w;
    int bad;
    w = $urandom_range(5, 300);
    wait_pos(1, 0);
    clear_logs();
    start = model_addr;
    delay_addr = start + 23'(w);
    delay_special = 2;
    cap = 1'b1;
    wait_pos(1, 1800);
    cap = 1'b0;
    delay_special = 0;
    build_expect(4, start, w + 1);
    bad = first_diff();
    checks++;
    if (req_h.size() !== 319 || load_d.size() !== 319 || bad !== -1) begin
      errors++;
      $display("FAIL underrun_fetch w=%0d got req=%0d load=%0d diff=%0d want 319 319 -1",
               w, req_h.size(), load_d.size(), bad);
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b want 1", underrun);
    end
    checks++;
    if (addr_unstable !== 1'b0) begin
      errors++;
      $display("FAIL addr_stable got unstable=%b want 0", addr_unstable);
    end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clr got %b want 0", underrun);
    end
    model_addr = start + 23'd320;
  endtask

  task automatic test_vid_base();
    logic [22:0] start;
    int bad;
    wait_pos(2, 0);
    clear_logs();
    start = model_addr;
    cap = 1'b1;
    wait_pos(2, 100);
    vid_base = 23'h010000;
    wait_pos(2, 1800);
    cap = 1'b0;
    res = 2'd1;
    build_expect(4, start, -1);
    bad = first_diff();
    checks++;
    if (req_h.size() !== 320 || bad !== -1) begin
      errors++;
      $display("FAIL base_midframe got req=%0d diff=%0d want 320 -1", req_h.size(), bad);
    end
    model_addr = 23'h010000;
  endtask

  task automatic test_res_change();
    int bad;
    wait_pos(1, 0);
    clear_logs();
    cap = 1'b1;
    wait_pos(1, 700);
    res = 2'd0;
    wait_pos(1, 1800);
    build_expect(8, model_addr, -1);
    bad = first_diff();
    checks++;
    if (req_a.size() == 0 || req_a[0] !== 23'h010000) begin
      errors++;
      $display("FAIL base_new_frame got %h want 010000", (req_a.size() > 0) ? req_a[0] : 23'h0);
    end
    checks++;
    if (req_h.size() !== 160 || load_d.size() !== 160 || bad !== -1) begin
      errors++;
      $display("FAIL res_keep_med got req=%0d load=%0d diff=%0d want 160 160 -1",
               req_h.size(), load_d.size(), bad);
    end
    checks++;
    if (de_h.size() !== 2 || de_h[0] !== 288 || de_h[1] !== 1568) begin
      errors++;
      $display("FAIL med_de got edges=%0d first=%0d want 288 and 1568",
               de_h.size(), (de_h.size() > 0) ? de_h[0] : -1);
    end
    model_addr = model_addr + 23'd160;
    wait_pos(2, 0);
    clear_logs();
    wait_pos(2, 1800);
    cap = 1'b0;
    build_expect(16, model_addr, -1);
    bad = first_diff();
    checks++;
    if (req_h.size() !== 80 || bad !== -1) begin
      errors++;
      $display("FAIL res_next_low got req=%0d diff=%0d want 80 -1", req_h.size(), bad);
    end
  endtask

  task automatic test_reset_midop();
    logic [22:0] base3;
    int n;
    int bad;
    base_delay = 5;
    wait_pos(3, 500);
    n = 0;
    while (mem_req !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1 || sh_de !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup got req=%b de=%b want 1 1", mem_req, sh_de);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || sh_load !== 1'b0 || sh_de !== 1'b0 || mem_addr !== 23'd0) begin
      errors++;
      $display("FAIL async_reset got req=%b load=%b de=%b addr=%h want 0", mem_req, sh_load,
               sh_de, mem_addr);
    end
    repeat (3) step();
    base_delay = 0;
    base3 = 23'($urandom);
    vid_base = base3;
    clear_logs();
    cap = 1'b1;
    reset = 1'b0;
    step();
    checks++;
    if (frame_start !== 1'b1 || hpos !== 0) begin
      errors++;
      $display("FAIL restart_hcount got fs=%b h=%0d want 1 0", frame_start, hpos);
    end
    wait_pos(1, 1800);
    cap = 1'b0;
    build_expect(16, base3, -1);
    bad = first_diff();
    checks++;
    if (req_v.size() == 0 || req_v[0] !== 1 || req_h[0] !== 256) begin
      errors++;
      $display("FAIL restart_first_fetch got v=%0d h=%0d want 1 256",
               (req_v.size() > 0) ? req_v[0] : -1, (req_h.size() > 0) ? req_h[0] : -1);
    end
    checks++;
    if (req_h.size() !== 80 || bad !== -1) begin
      errors++;
      $display("FAIL restart_line got req=%0d diff=%0d want 80 -1", req_h.size(), bad);
    end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_low();
    test_mono();
    test_underrun();
    test_vid_base();
    test_res_change();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
